aes_enc_iter: RTL and testbench

- Iterative AES-128 encryption core; the forward counterpart to the decryption-side inverse round blocks.
- Accepts one plaintext/key pair through a valid/ready handshake.
- Runs one full round per clock (SubBytes, ShiftRows, MixColumns, AddRoundKey), with on-the-fly forward key expansion.
- Presents the ciphertext through a valid/ready output handshake. Sits in the encryption datapath feeding the link/top level.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox.sv | 40 ++++
 rtl/aes_enc_iter.sv | 119 +++++++++++
 tb/tb_aes_enc_iter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and round helper functions.
package aes_pkg;

  localparam int unsigned NB      = 4;
  localparam int unsigned NK      = 4;
  localparam int unsigned AES_BLK = 128;
  localparam int unsigned RND_W   = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  // Round constant for key-expansion round rnd (1-based); 0 outside 1..10.
  function automatic logic [7:0] rcon_of(input logic [RND_W-1:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns; a[31:24] is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte (r,c) lives at index r+4c, MSB first.
  function automatic logic [AES_BLK-1:0] shift_rows(input logic [AES_BLK-1:0] s);
    logic [AES_BLK-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

  // a^254 is the inverse (and maps 0 to 0).
  always_comb begin
    w_x2   = gf_mul(i_a, i_a);
    w_x3   = gf_mul(w_x2, i_a);
    w_x6   = gf_mul(w_x3, w_x3);
    w_x12  = gf_mul(w_x6, w_x6);
    w_x15  = gf_mul(w_x12, w_x3);
    w_x30  = gf_mul(w_x15, w_x15);
    w_x60  = gf_mul(w_x30, w_x30);
    w_x120 = gf_mul(w_x60, w_x60);
    w_x240 = gf_mul(w_x120, w_x120);
    w_x252 = gf_mul(w_x240, w_x12);
    w_inv  = gf_mul(w_x252, w_x2);
    o_s    = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional build macro AES_ENC_LAST_KEY_EN adds the last_rk output (final round key).
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AES_BLK-1:0] pt,
  input  logic [AES_BLK-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AES_BLK-1:0] ct
`ifdef AES_ENC_LAST_KEY_EN
  ,
  output logic [AES_BLK-1:0] last_rk
`endif
);

  aes_state_e         r_state, w_state_n;
  logic [AES_BLK-1:0] r_st, r_rk, r_ct;
  logic [RND_W-1:0]   r_rnd;
  logic               r_in_ready, r_out_valid;
  logic               w_accept, w_last;
  logic [AES_BLK-1:0] w_sb, w_sr, w_mc, w_rk_n, w_st_n;
  logic [31:0]        w_rot, w_subw, w_k0, w_k1, w_k2, w_k3;

  assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_last   = (r_rnd == RND_W'(NR));

  // SubBytes on the state, then ShiftRows and MixColumns.
  for (genvar k = 0; k < 16; k++) begin : g_sb
    aes_sbox u_sbox (.i_a(r_st[127-8*k -: 8]), .o_s(w_sb[127-8*k -: 8]));
  end
  assign w_sr = shift_rows(w_sb);
  for (genvar c = 0; c < NB; c++) begin : g_mc
    assign w_mc[127-32*c -: 32] = mix_column(w_sr[127-32*c -: 32]);
  end

  // Forward key schedule: SubWord(RotWord(w3)) feeds the next w0.
  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  for (genvar k = 0; k < NK; k++) begin : g_kb
    aes_sbox u_sbox (.i_a(w_rot[31-8*k -: 8]), .o_s(w_subw[31-8*k -: 8]));
  end
  assign w_k0   = r_rk[127:96] ^ w_subw ^ {rcon_of(r_rnd), 24'h000000};
  assign w_k1   = r_rk[95:64] ^ w_k0;
  assign w_k2   = r_rk[63:32] ^ w_k1;
  assign w_k3   = r_rk[31:0]  ^ w_k2;
  assign w_rk_n = {w_k0, w_k1, w_k2, w_k3};
  assign w_st_n = (w_last ? w_sr : w_mc) ^ w_rk_n;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_n = ROUND;
      ROUND:   if (w_last) w_state_n = DONE;
      DONE:    if (out_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= '0;
      r_rk        <= '0;
      r_ct        <= '0;
      r_rnd       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready <= (w_state_n == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_st  <= pt ^ key;
            r_rk  <= key;
            r_rnd <= RND_W'(1);
          end
        end
        ROUND: begin
          r_st <= w_st_n;
          r_rk <= w_rk_n;
          if (w_last) begin
            r_ct        <= w_st_n;
            r_out_valid <= 1'b1;
          end else begin
            r_rnd <= r_rnd + RND_W'(1);
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ENC_LAST_KEY_EN
  logic [AES_BLK-1:0] r_last_rk;
  always_ff @(posedge clk) begin
    if (rst)                              r_last_rk <= '0;
    else if ((r_state == ROUND) && w_last) r_last_rk <= w_rk_n;
  end
  assign last_rk = r_last_rk;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ct        = r_ct;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: known-answer vectors plus handshake/reset corner cases.
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
`ifdef AES_ENC_LAST_KEY_EN
  logic [127:0] last_rk;
`endif

  aes_enc_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct)
`ifdef AES_ENC_LAST_KEY_EN
    ,
    .last_rk   (last_rk)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[4];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block and return once the acceptance edge has passed.
  task automatic send(input logic [127:0] p, input logic [127:0] k);
    bit ok;
    pt = p; key = k; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_out_valid", 128'(out_valid), 128'(0));
    chk("release_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    int lat;
    int acc[2];
    int hs[2];
    logic [127:0] got[2];
    int n_acc;
    int n_got;

    vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_ct", ct, 128'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Known-answer vectors with exact latency.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].pt, vecs[i].key);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(10));
      chk($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
`ifdef AES_ENC_LAST_KEY_EN
      if (i == 0) chk("vec0_last_rk", last_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
      release_out();
    end

    // Backpressure: ct held and no new acceptance while out_ready is low.
    send(vecs[0].pt, vecs[0].key);
    wait_out(lat);
    in_valid = 1'b1; pt = vecs[1].pt; key = vecs[1].key;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_ct", ct, vecs[0].ct);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    release_out();

    // Back-to-back with in_valid and out_ready held high.
    n_acc = 0; n_got = 0;
    acc[0] = 0; acc[1] = 0; hs[0] = 0; hs[1] = 0; got[0] = '0; got[1] = '0;
    in_valid = 1'b1; out_ready = 1'b1; pt = vecs[0].pt; key = vecs[0].key;
    for (int i = 0; i < 60 && n_got < 2; i++) begin
      if (in_valid && in_ready && n_acc < 2) begin
        acc[n_acc] = cyc + 1;
        n_acc++;
      end
      if (out_valid && n_got < 2) begin
        got[n_got] = ct;
        hs[n_got]  = cyc + 1;
        n_got++;
      end
      tick();
      if (n_acc == 1) begin
        pt = vecs[1].pt; key = vecs[1].key;
      end else if (n_acc == 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_count", 128'(n_got), 128'(2));
    chk("b2b_ct0", got[0], vecs[0].ct);
    chk("b2b_ct1", got[1], vecs[1].ct);
    chk("b2b_period", 128'(acc[1] - acc[0]), 128'(12));
    chk("b2b_accept_after_hs", 128'(acc[1] - hs[0]), 128'(1));
    tick();

    // Reset in the middle of the rounds discards the block.
    send(vecs[1].pt, vecs[1].key);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_ct", ct, 128'(0));
    tick();
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_no_residue", 128'(out_valid), 128'(0));
    send(vecs[0].pt, vecs[0].key);
    wait_out(lat);
    chk("midrst_latency", 128'(lat), 128'(10));
    chk("midrst_ct_after", ct, vecs[0].ct);
    release_out();

    // Garbage offered while busy must be ignored.
    send(vecs[0].pt, vecs[0].key);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      in_valid = (i % 2) == 1;
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
    chk("ignore_latency", 128'(lat), 128'(10));
    chk("ignore_ct", ct, vecs[0].ct);
    release_out();

    // out_ready with nothing pending has no effect.
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready_valid", 128'(out_valid), 128'(0));
    chk("idle_out_ready_in_ready", 128'(in_ready), 128'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
